adder_arbiter: RTL and testbench

ADDER_ARBITER -- requirements
Module: adder_arbiter

---
 rtl/adder_arbiter.sv | 136 +++++++++++++
 tb/tb_adder_arbiter.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/adder_arbiter.sv
// adder_arbiter: round-robin arbiter sharing one registered sign-magnitude adder among NUM_REQ requesters.
// Define ADDER_ARBITER_SAT_EN to saturate same-sign magnitude overflow instead of wrapping it.
module adder_arbiter #(
    parameter int N       = 16,
    parameter int NUM_REQ = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*N-1:0]       req_a,
    input  logic [NUM_REQ*N-1:0]       req_b,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [N-1:0]               rsp_data,
    output logic [$clog2(NUM_REQ)-1:0] rsp_id
);

    localparam int IDW = $clog2(NUM_REQ);
    localparam int M   = N - 1;
`ifdef ADDER_ARBITER_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef enum logic {
        IDLE,
        RESP
    } state_t;

    state_t         r_state;
    state_t         w_stateNext;
    logic [IDW-1:0] r_ptr;
    logic [IDW-1:0] r_rspId;
    logic [N-1:0]   r_rspData;

    logic [IDW-1:0] w_grantIdx;
    logic           w_grantValid;
    int             w_scanIdx;
    logic           w_accept;
    logic [IDW-1:0] w_ptrNext;

    logic [N-1:0]   w_opA;
    logic [N-1:0]   w_opB;
    logic [M-1:0]   w_magA;
    logic [M-1:0]   w_magB;
    logic [M:0]     w_magSum;
    logic           w_carry;
    logic [M-1:0]   w_magRes;
    logic           w_signRes;
    logic [N-1:0]   w_sum;

    // Scan requesters starting at r_ptr; the first valid one in that order wins.
    always_comb begin
        w_grantValid = 1'b0;
        w_grantIdx   = '0;
        w_scanIdx    = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_scanIdx = int'(r_ptr) + k;
            if (w_scanIdx >= NUM_REQ) begin
                w_scanIdx = w_scanIdx - NUM_REQ;
            end
            if (!w_grantValid && req_valid[w_scanIdx]) begin
                w_grantValid = 1'b1;
                w_grantIdx   = IDW'(w_scanIdx);
            end
        end
    end

    assign w_opA     = req_a[int'(w_grantIdx)*N +: N];
    assign w_opB     = req_b[int'(w_grantIdx)*N +: N];
    assign w_magA    = w_opA[M-1:0];
    assign w_magB    = w_opB[M-1:0];
    assign w_magSum  = {1'b0, w_magA} + {1'b0, w_magB};
    assign w_carry   = w_magSum[M];
    assign w_ptrNext = (w_grantIdx == IDW'(NUM_REQ - 1)) ? '0 : w_grantIdx + 1'b1;

    // Sign-magnitude add; a zero magnitude always comes out with a positive sign.
    always_comb begin
        w_magRes  = '0;
        w_signRes = 1'b0;
        if (w_opA[N-1] == w_opB[N-1]) begin
            w_signRes = w_opA[N-1];
            w_magRes  = (SAT && w_carry) ? {M{1'b1}} : w_magSum[M-1:0];
        end else if (w_magA >= w_magB) begin
            w_signRes = w_opA[N-1];
            w_magRes  = w_magA - w_magB;
        end else begin
            w_signRes = w_opB[N-1];
            w_magRes  = w_magB - w_magA;
        end
        w_sum = {w_signRes && (w_magRes != '0), w_magRes};
    end

    always_comb begin
        w_stateNext = r_state;
        req_ready   = '0;
        w_accept    = 1'b0;
        case (r_state)
            IDLE: begin
                if (!rst && w_grantValid) begin
                    req_ready[w_grantIdx] = 1'b1;
                    w_accept              = 1'b1;
                    w_stateNext           = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    w_stateNext = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_ptr     <= '0;
            r_rspData <= '0;
            r_rspId   <= '0;
        end else begin
            r_state <= w_stateNext;
            if (w_accept) begin
                r_rspData <= w_sum;
                r_rspId   <= w_grantIdx;
                r_ptr     <= w_ptrNext;
            end
        end
    end

    assign rsp_valid = (r_state == RESP);
    assign rsp_data  = r_rspData;
    assign rsp_id    = r_rspId;

endmodule

// File: tb/tb_adder_arbiter.sv
// tb_adder_arbiter: directed vectors for adder_arbiter; expected responses queue into a scoreboard
// that a free-running monitor drains on every response handshake.
module tb_adder_arbiter;

    localparam int N       = 16;
    localparam int NUM_REQ = 4;

    logic                 clk;
    logic                 rst;
    logic [NUM_REQ-1:0]   req_valid;
    logic [NUM_REQ-1:0]   req_ready;
    logic [NUM_REQ*N-1:0] req_a;
    logic [NUM_REQ*N-1:0] req_b;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [N-1:0]         rsp_data;
    logic [1:0]           rsp_id;

    int          nChecks = 0;
    int          nFails  = 0;
    logic [17:0] expQ[$];

    adder_arbiter #(.N(N), .NUM_REQ(NUM_REQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Monitor: every response handshake pops and checks the oldest expected result.
    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            if (expQ.size() == 0) begin
                nChecks++;
                nFails++;
                $display("[TB] FAIL unexpected_rsp: got data 0x%0h id %0d, expected no response", rsp_data, rsp_id);
            end else begin
                logic [17:0] e;
                e = expQ.pop_front();
                checkOutput("rsp_data", 32'(rsp_data), 32'(e[15:0]));
                checkOutput("rsp_id", 32'(rsp_id), 32'(e[17:16]));
            end
        end
    end

    // Presents one request from requester id; called just after a rising edge with the DUT idle.
    task automatic applyStimulus(input int id, input logic [15:0] a, input logic [15:0] b,
                                 input logic [15:0] expData, input bit doPush);
        logic [3:0] oneHot;
        oneHot = 4'(1 << id);
        req_a[id*N +: N] = a;
        req_b[id*N +: N] = b;
        req_valid = oneHot;
        @(negedge clk);
        checkOutput("grant", 32'(req_ready), 32'(oneHot));
        if (doPush) expQ.push_back({2'(id), expData});
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        checkOutput("latency_rsp_valid", 32'(rsp_valid), 32'd1);
    endtask

    task automatic waitIdle();
        bit done;
        done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!rsp_valid) begin
                done = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!done) checkOutput("wait_idle_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("reset_rsp_data", 32'(rsp_data), 32'd0);
        checkOutput("reset_rsp_id", 32'(rsp_id), 32'd0);
        checkOutput("reset_req_ready", 32'(req_ready), 32'd0);

        // Round robin with all requesters valid: ids 0,1,2,3,0, one accept every 2 cycles.
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_REQ; i++) begin
            req_a[i*N +: N] = 16'(i + 1);
            req_b[i*N +: N] = 16'h0010;
        end
        for (int k = 0; k < 5; k++) begin
            expQ.push_back({2'(k % 4), 16'(16'h0011 + (k % 4))});
        end
        req_valid = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("rr_grant", 32'(req_ready), 32'(1 << (k % 4)));
            @(posedge clk);
            #1;
            if (k == 4) req_valid = '0;
            @(negedge clk);
            checkOutput("rr_rsp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("rr_ready_in_resp", 32'(req_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        waitIdle();

        applyStimulus(0, 16'h0005, 16'h8003, 16'h0002, 1'b1);
        waitIdle();
        applyStimulus(1, 16'h8005, 16'h0005, 16'h0000, 1'b1);
        waitIdle();
`ifdef ADDER_ARBITER_SAT_EN
        applyStimulus(2, 16'hFFFF, 16'h8001, 16'hFFFF, 1'b1);
        waitIdle();
        applyStimulus(3, 16'h7FFF, 16'h0001, 16'h7FFF, 1'b1);
`else
        applyStimulus(2, 16'hFFFF, 16'h8001, 16'h0000, 1'b1);
        waitIdle();
        applyStimulus(3, 16'h7FFF, 16'h0001, 16'h0000, 1'b1);
`endif
        waitIdle();
        applyStimulus(0, 16'h0003, 16'h8005, 16'h8002, 1'b1);
        waitIdle();
        applyStimulus(3, 16'h8100, 16'h8023, 16'h8123, 1'b1);
        waitIdle();

        // Backpressure: result held stable, no grants, requester 2 waiting.
        rsp_ready = 1'b0;
        applyStimulus(1, 16'h1234, 16'h0100, 16'h1334, 1'b1);
        req_a[2*N +: N] = 16'h0001;
        req_b[2*N +: N] = 16'h0001;
        req_valid = 4'b0100;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'd1);
            checkOutput("bp_rsp_data", 32'(rsp_data), 32'h1334);
            checkOutput("bp_rsp_id", 32'(rsp_id), 32'd1);
            checkOutput("bp_req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("bp_next_grant", 32'(req_ready), 32'b0100);
        expQ.push_back({2'd2, 16'h0002});
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        checkOutput("bp_next_rsp_valid", 32'(rsp_valid), 32'd1);
        waitIdle();

        // Reset while a result is pending discards it and clears the pointer.
        rsp_ready = 1'b0;
        applyStimulus(1, 16'h0100, 16'h0100, 16'h0200, 1'b0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rst_mid_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_mid_rsp_data", 32'(rsp_data), 32'd0);
        checkOutput("rst_mid_rsp_id", 32'(rsp_id), 32'd0);
        #1 req_valid = 4'b1010;
        #1 checkOutput("rst_mid_ptr_zero", 32'(req_ready), 32'b0010);
        req_a[2*N +: N] = 16'h8007;
        req_b[2*N +: N] = 16'h0002;
        #1 req_valid = 4'b0100;
        #1 checkOutput("rst_mid_grant2", 32'(req_ready), 32'b0100);
        expQ.push_back({2'd2, 16'h8005});
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        checkOutput("rst_mid_rsp_after", 32'(rsp_valid), 32'd1);
        waitIdle();

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
